// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch front-panel sequencer.
// Holds the FSM state encoding and the default tuning constants.
package cronometro_pkg;

    typedef enum logic [2:0] {
        ST_CONFIG   = 3'd0,
        ST_CONTANDO = 3'd1,
        ST_PARCIAL  = 3'd2,
        ST_ALARME   = 3'd3
    } estado_t;

    localparam int SEG_POR_MIN    = 60;
    localparam int DEB_CICLOS_PAD = 1000000;
    localparam int MIN_MAX_PAD    = 99;
    localparam int SEG_MAX_PAD    = 59;

endpackage

// File: rtl/debounce_botao.sv
// Debouncer for one active-low pushbutton: 2-FF synchroniser, stability
// counter and a single-cycle press pulse on the debounced 1->0 edge.
module debounce_botao #(
    parameter int DEB_CICLOS = 1000000
) (
    input  logic clk,
    input  logic reseta_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any sample that agrees again discards the partial run.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CICLOS - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_n_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press_o = deb_prev_q & ~deb_q;

endmodule

// File: rtl/controle_cronometro.sv
// Front-panel sequencer: debounces the keys, holds the configured time and
// runs the mode FSM that drives the counter control lines.
module controle_cronometro
    import cronometro_pkg::*;
#(
    parameter int DEB_CICLOS = DEB_CICLOS_PAD,
    parameter int MIN_MAX    = MIN_MAX_PAD,
    parameter int SEG_MAX    = SEG_MAX_PAD
) (
    input  logic        clk,
    input  logic        reseta_n,
    input  logic        btn_cfg_n,
    input  logic        btn_start_n,
    input  logic        btn_zera_n,
    input  logic        btn_parcial_n,
    input  logic        btn_min_n,
    input  logic        btn_seg_n,
    input  logic        sw_modo,
    input  logic        tim1,
    output logic        sel,
    output logic [15:0] tempo,
    output logic        cfg,
    output logic        salve,
    output logic        pause,
    output logic        reseta,
    output logic        alarme,
    output logic [2:0]  estado
);

    logic    ev_cfg, ev_start, ev_zera, ev_parcial, ev_min, ev_seg;
    logic    tim1_ev;
    estado_t state_q;
    logic    cfg_q, salve_q, pause_q, reseta_q, alarme_q, sel_q, tim1_q;
    logic [6:0] min_q;
    logic [5:0] seg_q;
    logic [15:0] min_ext;

    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_cfg (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_cfg_n), .press_o(ev_cfg));
    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_start (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_start_n), .press_o(ev_start));
    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_zera (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_zera_n), .press_o(ev_zera));
    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_parcial (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_parcial_n), .press_o(ev_parcial));
    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_min (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_min_n), .press_o(ev_min));
    debounce_botao #(.DEB_CICLOS(DEB_CICLOS)) u_deb_seg (
        .clk(clk), .reseta_n(reseta_n), .btn_n_i(btn_seg_n), .press_o(ev_seg));

    assign tim1_ev = tim1 ^ tim1_q;

    // Event priority inside each running state is cfg > zera > tim1 > parcial.
    always_ff @(posedge clk or negedge reseta_n) begin
        if (!reseta_n) begin
            state_q  <= ST_CONFIG;
            cfg_q    <= 1'b1;
            salve_q  <= 1'b0;
            pause_q  <= 1'b0;
            reseta_q <= 1'b0;
            alarme_q <= 1'b0;
            sel_q    <= 1'b0;
            tim1_q   <= 1'b0;
            min_q    <= '0;
            seg_q    <= '0;
        end else begin
            tim1_q  <= tim1;
            salve_q <= 1'b0;
            case (state_q)
                ST_CONFIG: begin
                    sel_q <= sw_modo;
                    if (ev_min) begin
                        min_q <= (min_q == 7'(MIN_MAX)) ? 7'd0 : min_q + 7'd1;
                    end
                    if (ev_seg) begin
                        seg_q <= (seg_q == 6'(SEG_MAX)) ? 6'd0 : seg_q + 6'd1;
                    end
                    if (ev_zera) begin
                        min_q <= '0;
                        seg_q <= '0;
                    end
                    if (ev_start) begin
                        cfg_q   <= 1'b0;
                        salve_q <= 1'b1;
                        state_q <= ST_CONTANDO;
                    end
                end
                ST_CONTANDO: begin
                    if (ev_cfg) begin
                        cfg_q   <= 1'b1;
                        state_q <= ST_CONFIG;
                    end else if (ev_zera) begin
                        reseta_q <= ~reseta_q;
                    end else if (tim1_ev) begin
                        alarme_q <= 1'b1;
                        state_q  <= ST_ALARME;
                    end else if (ev_parcial) begin
                        pause_q <= 1'b1;
                        state_q <= ST_PARCIAL;
                    end
                end
                ST_PARCIAL: begin
                    if (ev_cfg) begin
                        cfg_q   <= 1'b1;
                        pause_q <= 1'b0;
                        state_q <= ST_CONFIG;
                    end else if (ev_zera) begin
                        reseta_q <= ~reseta_q;
                        pause_q  <= 1'b0;
                        state_q  <= ST_CONTANDO;
                    end else if (tim1_ev) begin
                        pause_q  <= 1'b0;
                        alarme_q <= 1'b1;
                        state_q  <= ST_ALARME;
                    end else if (ev_parcial) begin
                        pause_q <= 1'b0;
                        state_q <= ST_CONTANDO;
                    end
                end
                ST_ALARME: begin
                    if (ev_cfg) begin
                        cfg_q    <= 1'b1;
                        alarme_q <= 1'b0;
                        state_q  <= ST_CONFIG;
                    end else if (ev_zera) begin
                        reseta_q <= ~reseta_q;
                        alarme_q <= 1'b0;
                        state_q  <= ST_CONTANDO;
                    end
                end
                default: begin
                    cfg_q   <= 1'b1;
                    state_q <= ST_CONFIG;
                end
            endcase
        end
    end

    // min*60 as min*64 - min*4 keeps the conversion to shifts and adders.
    assign min_ext = {9'd0, min_q};
    assign tempo   = (min_ext << 6) - (min_ext << 2) + {10'd0, seg_q};

    assign sel    = sel_q;
    assign cfg    = cfg_q;
    assign salve  = salve_q;
    assign pause  = pause_q;
    assign reseta = reseta_q;
    assign alarme = alarme_q;
    assign estado = state_q;

endmodule

// File: tb/tb_controle_cronometro.sv
// Directed scoreboard bench for controle_cronometro with a short debounce.
module tb_controle_cronometro;

    localparam int DEB = 4;

    logic        clk;
    logic        reseta_n;
    logic        btn_cfg_n, btn_start_n, btn_zera_n, btn_parcial_n, btn_min_n, btn_seg_n;
    logic        sw_modo, tim1;
    logic        sel, cfg, salve, pause, reseta, alarme;
    logic [15:0] tempo;
    logic [2:0]  estado;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    localparam int B_CFG = 0, B_START = 1, B_ZERA = 2, B_PARCIAL = 3, B_MIN = 4, B_SEG = 5;

    controle_cronometro #(.DEB_CICLOS(DEB), .MIN_MAX(99), .SEG_MAX(59)) dut (
        .clk(clk), .reseta_n(reseta_n),
        .btn_cfg_n(btn_cfg_n), .btn_start_n(btn_start_n), .btn_zera_n(btn_zera_n),
        .btn_parcial_n(btn_parcial_n), .btn_min_n(btn_min_n), .btn_seg_n(btn_seg_n),
        .sw_modo(sw_modo), .tim1(tim1),
        .sel(sel), .tempo(tempo), .cfg(cfg), .salve(salve), .pause(pause),
        .reseta(reseta), .alarme(alarme), .estado(estado));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectVal(input string tag, input logic [15:0] v);
        expQ.push_back('{tag, v});
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, scoreboard empty", tag, obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.val && tag == e.tag) else begin
                failures++;
                $error("[TB] FAIL %s: observed %0d expected %0d (entry %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    task automatic setBtn(input int b, input logic v);
        case (b)
            B_CFG:     btn_cfg_n     = v;
            B_START:   btn_start_n   = v;
            B_ZERA:    btn_zera_n    = v;
            B_PARCIAL: btn_parcial_n = v;
            B_MIN:     btn_min_n     = v;
            default:   btn_seg_n     = v;
        endcase
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Hold a key for holdCycles, then release long enough to settle.
    task automatic applyStimulus(input int b, input int holdCycles);
        @(negedge clk);
        setBtn(b, 1'b0);
        waitCycles(holdCycles);
        setBtn(b, 1'b1);
        waitCycles(3 * DEB);
    endtask

    task automatic pressN(input int b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b, 3 * DEB);
    endtask

    int   salveCnt;
    logic cfgAtSalve;
    logic [2:0] estAtSalve;

    initial begin
        reseta_n = 1'b0;
        btn_cfg_n = 1'b1; btn_start_n = 1'b1; btn_zera_n = 1'b1;
        btn_parcial_n = 1'b1; btn_min_n = 1'b1; btn_seg_n = 1'b1;
        sw_modo = 1'b0; tim1 = 1'b0;
        waitCycles(3);

        expectVal("rst_estado", 0); checkOutput("rst_estado", 16'(estado));
        expectVal("rst_cfg", 1);    checkOutput("rst_cfg", 16'(cfg));
        expectVal("rst_salve", 0);  checkOutput("rst_salve", 16'(salve));
        expectVal("rst_pause", 0);  checkOutput("rst_pause", 16'(pause));
        expectVal("rst_reseta", 0); checkOutput("rst_reseta", 16'(reseta));
        expectVal("rst_alarme", 0); checkOutput("rst_alarme", 16'(alarme));
        expectVal("rst_sel", 0);    checkOutput("rst_sel", 16'(sel));
        expectVal("rst_tempo", 0);  checkOutput("rst_tempo", tempo);

        reseta_n = 1'b1;
        sw_modo  = 1'b1;
        pressN(B_MIN, 3);
        pressN(B_SEG, 15);
        expectVal("cfg_tempo", 16'd195); checkOutput("cfg_tempo", tempo);
        expectVal("cfg_sel", 1);         checkOutput("cfg_sel", 16'(sel));
        expectVal("cfg_cfg", 1);         checkOutput("cfg_cfg", 16'(cfg));
        expectVal("cfg_estado", 0);      checkOutput("cfg_estado", 16'(estado));

        // Long start hold must yield a single salve pulse.
        salveCnt = 0; cfgAtSalve = 1'b1; estAtSalve = 3'd7;
        @(negedge clk);
        btn_start_n = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (salve === 1'b1) begin
                if (salveCnt == 0) begin
                    cfgAtSalve = cfg;
                    estAtSalve = estado;
                end
                salveCnt++;
            end
        end
        btn_start_n = 1'b1;
        for (int i = 0; i < 3 * DEB; i++) begin
            @(negedge clk);
            if (salve === 1'b1) salveCnt++;
        end
        expectVal("salve_pulses", 1);   checkOutput("salve_pulses", 16'(salveCnt));
        expectVal("cfg_at_salve", 0);   checkOutput("cfg_at_salve", 16'(cfgAtSalve));
        expectVal("estado_at_salve", 1); checkOutput("estado_at_salve", 16'(estAtSalve));

        applyStimulus(B_PARCIAL, 3 * DEB);
        expectVal("parc_pause", 1);  checkOutput("parc_pause", 16'(pause));
        expectVal("parc_estado", 2); checkOutput("parc_estado", 16'(estado));
        applyStimulus(B_ZERA, 3 * DEB);
        expectVal("zera1_reseta", 1); checkOutput("zera1_reseta", 16'(reseta));
        expectVal("zera1_pause", 0);  checkOutput("zera1_pause", 16'(pause));
        expectVal("zera1_estado", 1); checkOutput("zera1_estado", 16'(estado));
        applyStimulus(B_ZERA, 3 * DEB);
        expectVal("zera2_reseta", 0); checkOutput("zera2_reseta", 16'(reseta));

        tim1 = 1'b1;
        @(negedge clk);
        expectVal("tim_alarme", 1); checkOutput("tim_alarme", 16'(alarme));
        expectVal("tim_estado", 3); checkOutput("tim_estado", 16'(estado));
        tim1 = 1'b0;
        waitCycles(3);
        expectVal("tim2_alarme", 1); checkOutput("tim2_alarme", 16'(alarme));
        expectVal("tim2_estado", 3); checkOutput("tim2_estado", 16'(estado));
        applyStimulus(B_ZERA, 3 * DEB);
        expectVal("alz_alarme", 0); checkOutput("alz_alarme", 16'(alarme));
        expectVal("alz_reseta", 1); checkOutput("alz_reseta", 16'(reseta));
        expectVal("alz_estado", 1); checkOutput("alz_estado", 16'(estado));

        // cfg event lands 2+DEB+1 edges after the key drops; align tim1 with it.
        applyStimulus(B_PARCIAL, 3 * DEB);
        expectVal("p2_estado", 2); checkOutput("p2_estado", 16'(estado));
        @(negedge clk);
        btn_cfg_n = 1'b0;
        for (int i = 0; i < 2 + DEB; i++) @(posedge clk);
        @(negedge clk);
        tim1 = 1'b1;
        @(negedge clk);
        expectVal("prio_estado", 0); checkOutput("prio_estado", 16'(estado));
        expectVal("prio_cfg", 1);    checkOutput("prio_cfg", 16'(cfg));
        expectVal("prio_alarme", 0); checkOutput("prio_alarme", 16'(alarme));
        expectVal("prio_pause", 0);  checkOutput("prio_pause", 16'(pause));
        waitCycles(3 * DEB);
        btn_cfg_n = 1'b1;
        waitCycles(3 * DEB);

        pressN(B_MIN, 96);
        expectVal("min99_tempo", 16'd5955); checkOutput("min99_tempo", tempo);
        pressN(B_MIN, 1);
        expectVal("minwrap_tempo", 16'd15); checkOutput("minwrap_tempo", tempo);
        pressN(B_MIN, 1);
        pressN(B_SEG, 44);
        expectVal("seg59_tempo", 16'd119); checkOutput("seg59_tempo", tempo);
        pressN(B_SEG, 1);
        expectVal("segwrap_tempo", 16'd60); checkOutput("segwrap_tempo", tempo);
        applyStimulus(B_ZERA, 3 * DEB);
        expectVal("cfgzera_tempo", 0);  checkOutput("cfgzera_tempo", tempo);
        expectVal("cfgzera_reseta", 1); checkOutput("cfgzera_reseta", 16'(reseta));

        applyStimulus(B_START, 3 * DEB);
        applyStimulus(B_PARCIAL, 3 * DEB);
        expectVal("p3_estado", 2); checkOutput("p3_estado", 16'(estado));
        @(negedge clk);
        btn_zera_n = 1'b0;
        waitCycles(DEB - 2);
        btn_zera_n = 1'b1;
        waitCycles(5 * DEB);
        expectVal("glitch_reseta", 1); checkOutput("glitch_reseta", 16'(reseta));
        expectVal("glitch_estado", 2); checkOutput("glitch_estado", 16'(estado));

        @(posedge clk);
        #2 reseta_n = 1'b0;
        #1;
        expectVal("arst_estado", 0); checkOutput("arst_estado", 16'(estado));
        expectVal("arst_pause", 0);  checkOutput("arst_pause", 16'(pause));
        expectVal("arst_cfg", 1);    checkOutput("arst_cfg", 16'(cfg));
        expectVal("arst_reseta", 0); checkOutput("arst_reseta", 16'(reseta));
        expectVal("arst_sel", 0);    checkOutput("arst_sel", 16'(sel));
        expectVal("arst_tempo", 0);  checkOutput("arst_tempo", tempo);

        waitCycles(2);
        reseta_n = 1'b1;
        waitCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
